// File: rtl/mdu_iter.sv
// mdu_iter: iterative MIPS multiply/divide unit with HI/LO registers.
// Optional build macro MDU_EARLY_OUT_EN: MUL exits early once the multiplier runs out.
module mdu_iter #(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            manclk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    input  logic            rd_req,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            dbz,
    output logic            stall_req,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    localparam logic [CNTW-1:0] LAST = CNTW'(XLEN - 1);

    state_t            state, state_n;
    logic [CNTW-1:0]   cnt;
    logic [2*XLEN-1:0] acc, acc_n;
    logic [XLEN-1:0]   pr, pr_n;
    logic [XLEN-1:0]   mc, mq, mq_n;
    logic              is_div, dz, qneg, rneg;

    logic              accept, eo, fin;
    logic              sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     msum, pr_sh, trial;
    logic [CNTW-1:0]   shamt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, remv;

    assign accept = (state == IDLE) && start && !kill;
    assign sa     = !op[0] && a[XLEN-1];
    assign sb     = !op[0] && b[XLEN-1];
    assign mag_a  = sa ? -a : a;
    assign mag_b  = sb ? -b : b;

    // MUL: mc = multiplicand, mq = multiplier shifting right.
    // DIV: mc = divisor, mq = dividend shifting out / quotient shifting in.
    assign msum  = {1'b0, acc[2*XLEN-1:XLEN]} + (mq[0] ? {1'b0, mc} : '0);
    assign pr_sh = {pr, mq[XLEN-1]};
    assign trial = pr_sh - {1'b0, mc};
    assign shamt = LAST - cnt;

    always_comb begin
        acc_n = acc;
        pr_n  = pr;
        mq_n  = mq;
        if (is_div) begin
            pr_n = trial[XLEN] ? pr_sh[XLEN-1:0] : trial[XLEN-1:0];
            mq_n = {mq[XLEN-2:0], !trial[XLEN]};
        end else begin
            acc_n = {msum, acc[XLEN-1:1]};
            mq_n  = mq >> 1;
        end
    end

`ifdef MDU_EARLY_OUT_EN
    assign eo = !is_div && (mq_n == '0);
`else
    assign eo = 1'b0;
`endif
    assign fin = (cnt == LAST) || eo;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = ITER;
            ITER:    if (kill) state_n = IDLE;
                     else if (fin) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIX) && !kill;
    assign stall_req = busy && (rd_req || hi_we || lo_we);

    assign prod = qneg ? -acc : acc;
    assign quo  = qneg ? -mq : mq;
    assign remv = rneg ? -pr : pr;

    always_ff @(posedge manclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge manclk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            pr     <= '0;
            mc     <= '0;
            mq     <= '0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            dbz    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        acc    <= '0;
                        pr     <= '0;
                        dbz    <= 1'b0;
                        is_div <= op[1];
                        dz     <= (b == '0);
                        qneg   <= sa ^ sb;
                        rneg   <= sa;
                        mc     <= op[1] ? mag_b : mag_a;
                        mq     <= op[1] ? mag_a : mag_b;
                    end else if (!start) begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                ITER: begin
                    cnt <= cnt + CNTW'(1);
                    pr  <= pr_n;
                    mq  <= mq_n;
                    // early exit skips the remaining zero-add shifts at once
                    acc <= eo ? (acc_n >> shamt) : acc_n;
                end
                FIX: begin
                    if (!kill) begin
                        dbz <= is_div && dz;
                        if (is_div) begin
                            hi <= remv;
                            lo <= dz ? '1 : quo;
                        end else begin
                            {hi, lo} <= prod;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
